sal_cfg_apb: RTL and testbench

APB-programmable timing configuration block for the SAL DDR controller. It holds a shadow copy of every DRAM timing field, writable over APB. On a software commit it copies the shadow set into the active timing outputs, but only while the scheduler reports idle, so no field changes under an in-flight command. It sits between the APB fabric and the scheduler/bank controllers that consume the timing fields.

---
 rtl/sal_cfg_apb.sv | 237 +++++++++++++++++++++++
 tb/tb_sal_cfg_apb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_cfg_apb.sv
// SAL DDR timing configuration block: APB-writable shadow timing set,
// copied atomically into the active set on commit once the scheduler is idle.
module sal_cfg_apb (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [11:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        ctrl_idle,
   output logic [3:0]  t_rcd_m1,
   output logic [3:0]  t_rp_m1,
   output logic [3:0]  t_ras_m1,
   output logic [3:0]  t_rtp_m1,
   output logic [3:0]  t_wtp_m1,
   output logic [3:0]  t_rrd_m1,
   output logic [3:0]  t_ccd_m1,
   output logic [3:0]  t_wtr_m1,
   output logic [3:0]  t_rtw_m1,
   output logic [3:0]  dfi_wren_lat,
   output logic [3:0]  dfi_rden_lat,
   output logic [7:0]  t_rfc_m1,
   output logic [7:0]  row_open_cnt,
   output logic        cfg_update
);

   localparam logic [3:0] T_RCD_VALUE_M1 = 4'd3;
   localparam logic [3:0] T_RP_VALUE_M1  = 4'd3;
   localparam logic [3:0] T_RAS_VALUE_M1 = 4'd8;
   localparam logic [3:0] T_RTP_VALUE_M1 = 4'd1;
   localparam logic [3:0] T_WTP_VALUE_M1 = 4'd4;
   localparam logic [3:0] T_RRD_VALUE_M1 = 4'd1;
   localparam logic [3:0] T_CCD_VALUE_M1 = 4'd3;
   localparam logic [3:0] T_WTR_VALUE_M1 = 4'd2;
   localparam logic [3:0] T_RTW_VALUE_M1 = 4'd5;
   localparam logic [3:0] WRITE_LATENCY  = 4'd4;
   localparam logic [3:0] READ_LATENCY   = 4'd6;
   localparam logic [7:0] T_RFC_VALUE_M1 = 8'h4F;
   localparam logic [7:0] ROW_OPEN_CNT   = 8'h40;

   typedef struct packed {
      logic [7:0] row_open;
      logic [7:0] rfc;
      logic [3:0] rden;
      logic [3:0] wren;
      logic [3:0] rtw;
      logic [3:0] wtr;
      logic [3:0] ccd;
      logic [3:0] rrd;
      logic [3:0] wtp;
      logic [3:0] rtp;
      logic [3:0] ras;
      logic [3:0] rp;
      logic [3:0] rcd;
   } timing_t;

   localparam timing_t TIMING_RST = '{
      row_open: ROW_OPEN_CNT,
      rfc:      T_RFC_VALUE_M1,
      rden:     READ_LATENCY,
      wren:     WRITE_LATENCY,
      rtw:      T_RTW_VALUE_M1,
      wtr:      T_WTR_VALUE_M1,
      ccd:      T_CCD_VALUE_M1,
      rrd:      T_RRD_VALUE_M1,
      wtp:      T_WTP_VALUE_M1,
      rtp:      T_RTP_VALUE_M1,
      ras:      T_RAS_VALUE_M1,
      rp:       T_RP_VALUE_M1,
      rcd:      T_RCD_VALUE_M1
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   timing_t     shadow_q, shadow_d;
   timing_t     active_q, active_d;
   logic        pending_q, pending_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        upd_q, upd_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pslverr_q, pslverr_d;

   logic [9:0]  widx;
   logic        sel_ctrl, sel_t0, sel_t1, sel_t2, sel_stat;
   logic        sel_tim, mapped, acc_err;
   logic        xfer, wr_ok, commit, apply;
   logic [31:0] rdata;
   logic        unused_ok;

   assign unused_ok = ^{paddr[1:0], pwdata[31:24]};

   // ---------------- APB slave FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (psel && penable) state_d = S_WAIT;
         S_WAIT:  state_d = psel ? S_DONE : S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pready = (state_q == S_DONE);
      xfer   = (state_q == S_WAIT) && psel;
   end

   // ---------------- address decode ----------------
   assign widx     = paddr[11:2];
   assign sel_ctrl = (widx == 10'd0);
   assign sel_t0   = (widx == 10'd1);
   assign sel_t1   = (widx == 10'd2);
   assign sel_t2   = (widx == 10'd3);
   assign sel_stat = (widx == 10'd4);
   assign sel_tim  = sel_t0 | sel_t1 | sel_t2;
   assign mapped   = sel_ctrl | sel_tim | sel_stat;

   // Shadow is frozen while a commit waits, so the applied set is well defined
   assign acc_err = !mapped
                  | (pwrite & sel_stat)
                  | (pwrite & sel_tim & pending_q);

   assign wr_ok  = xfer & pwrite & !acc_err;
   assign commit = wr_ok & sel_ctrl & pwdata[0];
   assign apply  = pending_q & ctrl_idle;

   always_comb begin
      rdata = '0;
      case (widx)
         10'd1: rdata = {12'h0, shadow_q.wtp, shadow_q.rtp,
                         shadow_q.ras, shadow_q.rp, shadow_q.rcd};
         10'd2: rdata = {8'h0, shadow_q.rden, shadow_q.wren,
                         shadow_q.rtw, shadow_q.wtr,
                         shadow_q.ccd, shadow_q.rrd};
         10'd3: rdata = {16'h0, shadow_q.row_open, shadow_q.rfc};
         10'd4: rdata = {16'h0, cnt_q, 6'h0, err_q, pending_q};
         default: rdata = '0;
      endcase
   end

   // ---------------- register next-state ----------------
   always_comb begin
      shadow_d = shadow_q;
      if (wr_ok && sel_t0) begin
         shadow_d.rcd = pwdata[3:0];
         shadow_d.rp  = pwdata[7:4];
         shadow_d.ras = pwdata[11:8];
         shadow_d.rtp = pwdata[15:12];
         shadow_d.wtp = pwdata[19:16];
      end
      if (wr_ok && sel_t1) begin
         shadow_d.rrd  = pwdata[3:0];
         shadow_d.ccd  = pwdata[7:4];
         shadow_d.wtr  = pwdata[11:8];
         shadow_d.rtw  = pwdata[15:12];
         shadow_d.wren = pwdata[19:16];
         shadow_d.rden = pwdata[23:20];
      end
      if (wr_ok && sel_t2) begin
         shadow_d.rfc      = pwdata[7:0];
         shadow_d.row_open = pwdata[15:8];
      end
   end

   always_comb begin
      active_d  = apply ? shadow_q : active_q;
      pending_d = pending_q ? !apply : commit;
      cnt_d     = cnt_q + {7'd0, apply};
      upd_d     = apply;
      err_d     = err_q | (xfer & acc_err);
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      if (xfer) begin
         prdata_d  = (pwrite || acc_err) ? 32'h0 : rdata;
         pslverr_d = acc_err;
      end else if (state_q == S_DONE) begin
         prdata_d  = 32'h0;
         pslverr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q  <= TIMING_RST;
         active_q  <= TIMING_RST;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= 8'h0;
         upd_q     <= 1'b0;
         prdata_q  <= 32'h0;
         pslverr_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         upd_q     <= upd_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   // ---------------- outputs ----------------
   assign prdata       = prdata_q;
   assign pslverr      = pslverr_q;
   assign cfg_update   = upd_q;
   assign t_rcd_m1     = active_q.rcd;
   assign t_rp_m1      = active_q.rp;
   assign t_ras_m1     = active_q.ras;
   assign t_rtp_m1     = active_q.rtp;
   assign t_wtp_m1     = active_q.wtp;
   assign t_rrd_m1     = active_q.rrd;
   assign t_ccd_m1     = active_q.ccd;
   assign t_wtr_m1     = active_q.wtr;
   assign t_rtw_m1     = active_q.rtw;
   assign dfi_wren_lat = active_q.wren;
   assign dfi_rden_lat = active_q.rden;
   assign t_rfc_m1     = active_q.rfc;
   assign row_open_cnt = active_q.row_open;

endmodule

// File: tb/tb_sal_cfg_apb.sv
// Bench for sal_cfg_apb: directed plan plus random APB traffic
// against a word-level register model stepped once per clock edge.
module tb_sal_cfg_apb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic        ctrl_idle = 1'b0;
   logic [31:0] prdata;
   logic        pready, pslverr, cfg_update;
   logic [3:0]  t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1;
   logic [3:0]  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
   logic [3:0]  dfi_wren_lat, dfi_rden_lat;
   logic [7:0]  t_rfc_m1, row_open_cnt;

   sal_cfg_apb dut (
      .clk(clk), .rst(rst),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .ctrl_idle(ctrl_idle),
      .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
      .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .t_rrd_m1(t_rrd_m1),
      .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
      .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat),
      .t_rfc_m1(t_rfc_m1), .row_open_cnt(row_open_cnt),
      .cfg_update(cfg_update)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] DEF0 = 32'h0004_1833;
   localparam logic [31:0] DEF1 = 32'h0064_5231;
   localparam logic [31:0] DEF2 = 32'h0000_404F;

   int checks = 0;
   int failures = 0;
   int upd_seen = 0;

   logic [31:0] m_sh [3];
   logic [31:0] m_act [3];
   logic        m_pend, m_err;
   logic [7:0]  m_cnt;
   logic        exp_rdy;
   logic        op_now = 1'b0, op_wr = 1'b0;
   logic [11:0] op_addr = '0;
   logic [31:0] op_wdata = '0;
   logic [31:0] exp_rd = '0;
   logic        exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fmask(input int i);
      case (i)
         0: return 32'h000F_FFFF;
         1: return 32'h00FF_FFFF;
         default: return 32'h0000_FFFF;
      endcase
   endfunction

   function automatic logic [31:0] act_word(input int i);
      case (i)
         0: return {12'h0, t_wtp_m1, t_rtp_m1, t_ras_m1, t_rp_m1, t_rcd_m1};
         1: return {8'h0, dfi_rden_lat, dfi_wren_lat, t_rtw_m1,
                    t_wtr_m1, t_ccd_m1, t_rrd_m1};
         default: return {16'h0, row_open_cnt, t_rfc_m1};
      endcase
   endfunction

   task automatic model_reset();
      m_sh   = '{DEF0, DEF1, DEF2};
      m_act  = '{DEF0, DEF1, DEF2};
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 8'h0;
      exp_rdy = 1'b0;
   endtask

   // One clock edge: advance the model, then check the DUT after settling
   task automatic tick();
      logic apply, old_pend, aerr, is_tim;
      int   idx;
      @(posedge clk);
      apply = 1'b0;
      aerr = 1'b0;
      is_tim = 1'b0;
      idx = 0;
      exp_rdy = 1'b0;
      if (!rst) begin
         old_pend = m_pend;
         apply = m_pend && ctrl_idle;
         if (op_now) begin
            idx = int'(op_addr[11:2]);
            is_tim = (idx >= 1) && (idx <= 3);
            aerr = (idx > 4) || (op_wr && (idx == 4 || (is_tim && old_pend)));
            exp_err = aerr;
            exp_rd = 32'h0;
            if (!op_wr && !aerr) begin
               if (is_tim) exp_rd = m_sh[idx-1];
               else if (idx == 4)
                  exp_rd = {16'h0, m_cnt, 6'h0, m_err, m_pend};
            end
            if (aerr) m_err = 1'b1;
            exp_rdy = 1'b1;
         end
         if (apply) begin
            m_act = m_sh;
            m_cnt = m_cnt + 8'd1;
            m_pend = 1'b0;
         end
         if (op_now && op_wr && !aerr) begin
            if (is_tim) m_sh[idx-1] = op_wdata & fmask(idx-1);
            if (idx == 0 && op_wdata[0] && !old_pend) m_pend = 1'b1;
         end
      end
      #1;
      check("pready", 32'(pready), 32'(exp_rdy));
      check("cfg_update", 32'(cfg_update), 32'(apply));
      if (cfg_update) upd_seen++;
      for (int i = 0; i < 3; i++) check("active", act_word(i), m_act[i]);
   endtask

   task automatic apb(input logic wr, input logic [11:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
      psel = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      tick();
      op_now = 1'b1; op_wr = wr; op_addr = a; op_wdata = d;
      tick();
      op_now = 1'b0;
      rd = prdata;
      er = pslverr;
      if (!wr) check("prdata", rd, exp_rd);
      check("pslverr", 32'(er), 32'(exp_err));
      psel = 1'b0; penable = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   logic [7:0]  cnt0;

   initial begin
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset values
      apb(1'b0, 12'h004, 0, rd, er); check("rst_t0", rd, DEF0);
      apb(1'b0, 12'h008, 0, rd, er); check("rst_t1", rd, DEF1);
      apb(1'b0, 12'h00C, 0, rd, er); check("rst_t2", rd, DEF2);
      apb(1'b0, 12'h010, 0, rd, er); check("rst_stat", rd, 32'h0);
      apb(1'b0, 12'h000, 0, rd, er); check("rst_ctrl", rd, 32'h0);

      // shadow write, active untouched
      ctrl_idle = 1'b0;
      apb(1'b1, 12'h004, 32'h0003_2A75, rd, er);
      check("wr_t0_err", 32'(er), 32'h0);
      apb(1'b0, 12'h004, 0, rd, er); check("rb_t0", rd, 32'h0003_2A75);
      check("act_keep", act_word(0), DEF0);

      // commit held off by ctrl_idle low
      apb(1'b1, 12'h000, 32'h1, rd, er);
      for (int i = 0; i < 3; i++) begin
         apb(1'b0, 12'h010, 0, rd, er);
         check("pend_hold", rd & 32'h1, 32'h1);
      end
      ctrl_idle = 1'b1;
      tick();
      check("rcd", 32'(t_rcd_m1), 32'h5);
      check("rp", 32'(t_rp_m1), 32'h7);
      check("ras", 32'(t_ras_m1), 32'hA);
      check("rtp", 32'(t_rtp_m1), 32'h2);
      check("wtp", 32'(t_wtp_m1), 32'h3);
      check("upd_pulse", 32'(cfg_update), 32'h1);
      tick();
      check("upd_once", 32'(cfg_update), 32'h0);
      apb(1'b0, 12'h010, 0, rd, er); check("stat_apply", rd, 32'h0100);

      // errors
      ctrl_idle = 1'b0;
      apb(1'b1, 12'h000, 32'h1, rd, er);
      apb(1'b1, 12'h00C, 32'h0000_1234, rd, er);
      check("t2_pend_err", 32'(er), 32'h1);
      apb(1'b0, 12'h00C, 0, rd, er); check("t2_keep", rd, DEF2);
      apb(1'b0, 12'h010, 0, rd, er); check("stat_err", rd, 32'h0103);
      apb(1'b1, 12'h01C, 32'hFFFF_FFFF, rd, er);
      check("unmap_wr", 32'(er), 32'h1);
      apb(1'b0, 12'h01C, 0, rd, er);
      check("unmap_rd", rd, 32'h0);
      check("unmap_rd_err", 32'(er), 32'h1);
      apb(1'b1, 12'h010, 32'hFFFF_FFFF, rd, er);
      check("stat_wr_err", 32'(er), 32'h1);
      ctrl_idle = 1'b1;
      tick();

      // aborted transfer leaves shadow alone
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 12'h008; pwdata = 32'h00AB_CDEF;
      tick();
      penable = 1'b1;
      tick();
      psel = 1'b0; penable = 1'b0;
      tick();
      apb(1'b0, 12'h008, 0, rd, er); check("abort_keep", rd, DEF1);

      // 256 commits wrap apply_cnt
      apb(1'b0, 12'h010, 0, rd, er);
      cnt0 = rd[15:8];
      upd_seen = 0;
      for (int i = 0; i < 256; i++) apb(1'b1, 12'h000, 32'h1, rd, er);
      repeat (2) tick();
      check("upd_count", 32'(upd_seen), 32'd256);
      apb(1'b0, 12'h010, 0, rd, er);
      check("cnt_wrap", 32'(rd[15:8]), 32'(cnt0));

      // random traffic
      for (int n = 0; n < 400; n++) begin
         int k;
         logic [11:0] a;
         k = int'($urandom_range(0, 9));
         ctrl_idle = ($urandom_range(0, 2) == 0);
         a = {5'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         if (k <= 3)
            apb(1'b1, {8'd0, 2'($urandom_range(1, 3)), 2'd0}, $urandom, rd, er);
         else if (k <= 5)
            apb(1'b1, 12'h000, {31'd0, 1'($urandom_range(0, 3) != 0)}, rd, er);
         else if (k <= 7)
            apb(1'b0, a, 0, rd, er);
         else if (k == 8)
            apb(1'b1, a, $urandom, rd, er);
         else
            repeat ($urandom_range(1, 4)) tick();
      end

      // reset while pending and mid-WAIT
      ctrl_idle = 1'b0;
      apb(1'b1, 12'h000, 32'h1, rd, er);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 12'h004; pwdata = $urandom;
      tick();
      penable = 1'b1;
      tick();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rstm_pready", 32'(pready), 32'h0);
      check("rstm_upd", 32'(cfg_update), 32'h0);
      for (int i = 0; i < 3; i++) check("rstm_act", act_word(i), m_act[i]);
      psel = 1'b0; penable = 1'b0; ctrl_idle = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      upd_seen = 0;
      repeat (5) tick();
      check("rstm_noupd", 32'(upd_seen), 32'h0);
      apb(1'b0, 12'h010, 0, rd, er); check("rstm_stat", rd, 32'h0);
      apb(1'b0, 12'h004, 0, rd, er); check("rstm_t0", rd, DEF0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
